// File: rtl/cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// cache_miss_ctrl
//
// Miss-handling sequencer for a direct-mapped, write-back data cache. One CPU
// request is in flight at a time. The controller latches the request, then
// looks it up in the array (the tag compare is external and combinational).
// On a miss it writes back a dirty victim block word by word, refills the
// block from memory, commits the new tag, and replays the request.
//
// Optional feature: define CACHE_MISS_CTRL_STATS_EN to add the saturating
// 16-bit hit_count / miss_count ports. Without it the ports are absent and
// all other behaviour is identical.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr  request strobe (sampled in IDLE only), write flag, address
//   cpu_ready        one-cycle completion pulse
//   hit_miss         registered, 1 = last completed request hit
//   lk_addr          latched request address presented to the array lookup
//   tag_hit, victim_dirty, victim_base   array lookup results
//   arr_we, arr_fill, arr_word, arr_commit, arr_dirty   array controls
//   mem_req, mem_we, mem_addr, mem_ack   word-serial memory handshake
//   hit_count, miss_count (stats build only)
//
// All outputs except hit_miss and lk_addr are decoded combinationally from
// state, cnt and the lookup inputs, so a hit completes in the cycle right
// after the request is accepted.
// ---------------------------------------------------------------------------
module cache_miss_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [ADDR_W-1:0]              cpu_addr,
  output logic                           cpu_ready,
  output logic                           hit_miss,
  output logic [ADDR_W-1:0]              lk_addr,
  input  logic                           tag_hit,
  input  logic                           victim_dirty,
  input  logic [ADDR_W-1:0]              victim_base,
  output logic                           arr_we,
  output logic                           arr_fill,
  output logic [$clog2(BLOCK_WORDS)-1:0] arr_word,
  output logic                           arr_commit,
  output logic                           arr_dirty,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
`ifdef CACHE_MISS_CTRL_STATS_EN
  output logic [15:0]                    hit_count,
  output logic [15:0]                    miss_count,
`endif
  input  logic                           mem_ack
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);

  // Word-offset bits of an address; used to block-align the victim base.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);
  localparam logic [OFF_W-1:0]  LAST_CNT = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    COMMIT    = 3'd4
  } state_t;

  state_t             state;
  logic [OFF_W-1:0]   cnt;
  logic               lk_we;
  logic               last_word;
  logic [ADDR_W-1:0]  wb_base;

  assign last_word = (cnt == LAST_CNT);

  // The victim base is treated as block-aligned: any offset bits presented by
  // the array are discarded so the writeback always covers the whole block.
  assign wb_base = victim_base & ~OFF_MASK;

  // Sequencer: state, word counter, latched request and hit/miss status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= {OFF_W{1'b0}};
      lk_addr  <= {ADDR_W{1'b0}};
      lk_we    <= 1'b0;
      hit_miss <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            lk_addr <= cpu_addr;
            lk_we   <= cpu_we;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (tag_hit) begin
            hit_miss <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt   <= {OFF_W{1'b0}};
            state <= victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (last_word) begin
              cnt   <= {OFF_W{1'b0}};
              state <= REFILL;
            end else begin
              cnt <= cnt + OFF_W'(1);
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            // On the last word the counter wraps back to zero by itself.
            cnt <= cnt + OFF_W'(1);
            if (last_word) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          hit_miss <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          cnt   <= {OFF_W{1'b0}};
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: handshakes and array controls from state, cnt and lookup.
  always_comb begin
    cpu_ready  = 1'b0;
    arr_we     = 1'b0;
    arr_fill   = 1'b0;
    arr_word   = {OFF_W{1'b0}};
    arr_commit = 1'b0;
    arr_dirty  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    case (state)
      IDLE: begin
        cpu_ready = 1'b0;
      end
      LOOKUP: begin
        arr_word = lk_addr[OFF_W-1:0];
        if (tag_hit) begin
          cpu_ready = 1'b1;
          arr_we    = lk_we;
          arr_dirty = lk_we;
        end else begin
          cpu_ready = 1'b0;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wb_base | ADDR_W'(cnt);
        arr_word = cnt;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = {lk_addr[ADDR_W-1:OFF_W], cnt};
        arr_word = cnt;
        if (mem_ack) begin
          arr_we   = 1'b1;
          arr_fill = 1'b1;
        end else begin
          arr_we   = 1'b0;
        end
      end
      COMMIT: begin
        // Replaying a write marks the freshly committed line dirty; the array
        // gives arr_dirty priority over the clean state implied by arr_commit.
        cpu_ready  = 1'b1;
        arr_commit = 1'b1;
        arr_word   = lk_addr[OFF_W-1:0];
        arr_we     = lk_we;
        arr_dirty  = lk_we;
      end
      default: begin
        cpu_ready = 1'b0;
      end
    endcase
  end

`ifdef CACHE_MISS_CTRL_STATS_EN
  // Saturating hit/miss counters, stepped on each completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else begin
      if ((state == LOOKUP) && tag_hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'h0001;
      end
      if ((state == COMMIT) && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_miss_ctrl
//
// Directed bench for cache_miss_ctrl (ADDR_W=10, BLOCK_WORDS=4). The array
// lookup results and memory acknowledges are driven directly per scenario;
// outputs are sampled on the falling clock edge, inputs change there too.
// ---------------------------------------------------------------------------
module tb_cache_miss_ctrl;

  logic       clock;
  logic       reset_n;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic       cpu_ready;
  logic       hit_miss;
  logic [9:0] lk_addr;
  logic       tag_hit;
  logic       victim_dirty;
  logic [9:0] victim_base;
  logic       arr_we;
  logic       arr_fill;
  logic [1:0] arr_word;
  logic       arr_commit;
  logic       arr_dirty;
  logic       mem_req;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic       mem_ack;
`ifdef CACHE_MISS_CTRL_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  cache_miss_ctrl #(.ADDR_W(10), .BLOCK_WORDS(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_ready    (cpu_ready),
    .hit_miss     (hit_miss),
    .lk_addr      (lk_addr),
    .tag_hit      (tag_hit),
    .victim_dirty (victim_dirty),
    .victim_base  (victim_base),
    .arr_we       (arr_we),
    .arr_fill     (arr_fill),
    .arr_word     (arr_word),
    .arr_commit   (arr_commit),
    .arr_dirty    (arr_dirty),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
`ifdef CACHE_MISS_CTRL_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .mem_ack      (mem_ack)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h000;
    tag_hit = 1'b0; victim_dirty = 1'b0; victim_base = 10'h000; mem_ack = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ready",  32'(cpu_ready),  32'd0);
    check("rst_hm",     32'(hit_miss),   32'd0);
    check("rst_lk",     32'(lk_addr),    32'd0);
    check("rst_memreq", 32'(mem_req),    32'd0);
    check("rst_memwe",  32'(mem_we),     32'd0);
    check("rst_arrwe",  32'(arr_we),     32'd0);
    check("rst_commit", 32'(arr_commit), 32'd0);
    reset_n = 1'b1;

    // Read hit at 0x014
    cpu_req = 1'b1; cpu_addr = 10'h014; cpu_we = 1'b0; tag_hit = 1'b1;
    @(negedge clock); cpu_req = 1'b0;
    check("rh_ready",  32'(cpu_ready), 32'd1);
    check("rh_memreq", 32'(mem_req),   32'd0);
    check("rh_lk",     32'(lk_addr),   32'h014);
    check("rh_arrwe",  32'(arr_we),    32'd0);
    @(negedge clock);
    check("rh_hm",     32'(hit_miss),  32'd1);
    check("rh_idle",   32'(cpu_ready), 32'd0);

    // Write hit at 0x017
    cpu_req = 1'b1; cpu_addr = 10'h017; cpu_we = 1'b1; tag_hit = 1'b1;
    @(negedge clock); cpu_req = 1'b0;
    check("wh_ready",  32'(cpu_ready),  32'd1);
    check("wh_arrwe",  32'(arr_we),     32'd1);
    check("wh_fill",   32'(arr_fill),   32'd0);
    check("wh_dirty",  32'(arr_dirty),  32'd1);
    check("wh_word",   32'(arr_word),   32'd3);
    check("wh_commit", 32'(arr_commit), 32'd0);
    @(negedge clock);

    // Read miss at 0x020 issued back-to-back, clean victim, zero-wait memory
    cpu_req = 1'b1; cpu_addr = 10'h020; cpu_we = 1'b0; tag_hit = 1'b0;
    victim_dirty = 1'b0; mem_ack = 1'b1;
    @(negedge clock); cpu_req = 1'b0;
    check("rm_lk",     32'(lk_addr),   32'h020);
    check("rm_lkrdy",  32'(cpu_ready), 32'd0);
    check("rm_lkmem",  32'(mem_req),   32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rm_memreq", 32'(mem_req),  32'd1);
      check("rm_memwe",  32'(mem_we),   32'd0);
      check("rm_addr",   32'(mem_addr), 32'h020 + 32'(i));
      check("rm_arrwe",  32'(arr_we),   32'd1);
      check("rm_fill",   32'(arr_fill), 32'd1);
      check("rm_word",   32'(arr_word), 32'(i));
    end
    @(negedge clock);
    check("rm_ready",  32'(cpu_ready),  32'd1);
    check("rm_commit", 32'(arr_commit), 32'd1);
    check("rm_arrwe2", 32'(arr_we),     32'd0);
    check("rm_dirty",  32'(arr_dirty),  32'd0);
    check("rm_memreq2",32'(mem_req),    32'd0);
    @(negedge clock);
    check("rm_hm",     32'(hit_miss),   32'd0);
    check("rm_idle",   32'(cpu_ready),  32'd0);

    // Write miss at 0x041, dirty victim at 0x101 (aligned to 0x100)
    cpu_req = 1'b1; cpu_addr = 10'h041; cpu_we = 1'b1; tag_hit = 1'b0;
    victim_dirty = 1'b1; victim_base = 10'h101; mem_ack = 1'b1;
    @(negedge clock); cpu_req = 1'b0;
    check("wm_lkmem", 32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wm_wbreq",  32'(mem_req),  32'd1);
      check("wm_wbwe",   32'(mem_we),   32'd1);
      check("wm_wbaddr", 32'(mem_addr), 32'h100 + 32'(i));
      check("wm_wbword", 32'(arr_word), 32'(i));
      check("wm_wbarr",  32'(arr_we),   32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wm_rfwe",   32'(mem_we),   32'd0);
      check("wm_rfaddr", 32'(mem_addr), 32'h040 + 32'(i));
      check("wm_rfarr",  32'(arr_we),   32'd1);
      check("wm_rffill", 32'(arr_fill), 32'd1);
    end
    @(negedge clock);
    check("wm_ready",  32'(cpu_ready),  32'd1);
    check("wm_commit", 32'(arr_commit), 32'd1);
    check("wm_arrwe",  32'(arr_we),     32'd1);
    check("wm_fill",   32'(arr_fill),   32'd0);
    check("wm_dirty",  32'(arr_dirty),  32'd1);
    check("wm_word",   32'(arr_word),   32'd1);
    @(negedge clock);
    check("wm_hm",     32'(hit_miss),   32'd0);
    victim_dirty = 1'b0;

    // Read miss at 0x080 with three wait cycles before each memory ack
    cpu_req = 1'b1; cpu_addr = 10'h080; cpu_we = 1'b0; tag_hit = 1'b0; mem_ack = 1'b0;
    @(negedge clock); cpu_req = 1'b0;
    for (int w = 0; w < 4; w++) begin
      repeat (3) begin
        @(negedge clock);
        check("ws_req",   32'(mem_req),  32'd1);
        check("ws_addr",  32'(mem_addr), 32'h080 + 32'(w));
        check("ws_arrwe", 32'(arr_we),   32'd0);
      end
      mem_ack = 1'b1;
      #1;
      check("ws_ackwe",   32'(arr_we),   32'd1);
      check("ws_ackword", 32'(arr_word), 32'(w));
      @(posedge clock);
      #1 mem_ack = 1'b0;
    end
    @(negedge clock);
    check("ws_ready",  32'(cpu_ready),  32'd1);
    check("ws_commit", 32'(arr_commit), 32'd1);
    @(negedge clock);
`ifdef CACHE_MISS_CTRL_STATS_EN
    check("st_hits",   32'(hit_count),  32'd2);
    check("st_misses", 32'(miss_count), 32'd3);
`endif

    // Reset asserted during refill word 2 of a miss at 0x0C0
    cpu_req = 1'b1; cpu_addr = 10'h0C0; cpu_we = 1'b0; tag_hit = 1'b0; mem_ack = 1'b1;
    @(negedge clock); cpu_req = 1'b0;
    repeat (3) @(negedge clock);
    check("ra_addr",   32'(mem_addr), 32'h0C2);
    reset_n = 1'b0;
    #1;
    check("ra_memreq", 32'(mem_req),  32'd0);
    check("ra_lk",     32'(lk_addr),  32'd0);
    check("ra_arrwe",  32'(arr_we),   32'd0);
    mem_ack = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cpu_req = 1'b1; cpu_addr = 10'h0C4; tag_hit = 1'b1;
    @(negedge clock); cpu_req = 1'b0;
    check("ra_ready",  32'(cpu_ready), 32'd1);
    check("ra_lk2",    32'(lk_addr),   32'h0C4);
    check("ra_memreq2",32'(mem_req),   32'd0);
    @(negedge clock);
    check("ra_hm",     32'(hit_miss),  32'd1);
    check("ra_idle",   32'(cpu_ready), 32'd0);
`ifdef CACHE_MISS_CTRL_STATS_EN
    check("st_hits2",   32'(hit_count),  32'd1);
    check("st_misses2", 32'(miss_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
